// File: rtl/cp0_if.sv
// cp0_if: MIPS CP0 register file bus; master drives mtc0/mfc0/exception inputs, slave is the register file.
interface cp0_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic        timer_int_o;
    modport master (
        output we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
               current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
        input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
               badvaddr_o, timer_int_o
    );
    modport slave (
        input  we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
               current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
        output data_o, count_o, compare_o, status_o, cause_o, epc_o,
               badvaddr_o, timer_int_o
    );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 EPC/Cause/Status/BadVAddr/Count/Compare; timer interrupt enabled by CP0_TIMER_INT_EN.
module cp0_regfile (
    input logic  clk,
    input logic  resetn,
    cp0_if.slave bus
);
    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic        w_exc;
    logic        w_badv;
    logic        w_eret;
    logic        w_hit;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic [31:0] w_status;
    logic [31:0] w_cause;

`ifdef CP0_TIMER_INT_EN
    assign w_hit = (r_compare != 32'h0) && (r_count == r_compare);
`else
    assign w_hit = 1'b0;
`endif

    assign w_wr_count   = bus.we_i && bus.waddr_i == 5'd9;
    assign w_wr_compare = bus.we_i && bus.waddr_i == 5'd11;
    assign w_status     = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause      = {r_bd, r_timer_int, 14'b0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b0};

    // Decode the MEM-stage exception code into commit / address-error / eret strobes
    always_comb begin
        w_badv = bus.excepttype_i == 32'h4 || bus.excepttype_i == 32'h5;
        w_exc  = bus.excepttype_i == 32'h1 || w_badv || bus.excepttype_i == 32'h8 ||
                 bus.excepttype_i == 32'h9 || bus.excepttype_i == 32'ha || bus.excepttype_i == 32'hc;
        w_eret = bus.excepttype_i == 32'he;
    end

    // Half-rate Count, Compare, and the sticky timer interrupt (Compare write clears it, winning over a match)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick      <= 1'b0;
            r_count     <= 32'h0;
            r_compare   <= 32'h0;
            r_timer_int <= 1'b0;
        end else begin
            r_tick      <= w_wr_count ? 1'b0 : ~r_tick;
            r_count     <= w_wr_count ? bus.data_i : r_count + {31'b0, r_tick};
            r_compare   <= w_wr_compare ? bus.data_i : r_compare;
            r_timer_int <= !w_wr_compare && (r_timer_int || w_hit);
        end
    end

    // Exception/eret commit takes priority over mtc0 to Status/Cause/EPC; hardware IP reloads every cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_im       <= 8'h0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip_hw    <= 6'h0;
            r_ip_sw    <= 2'h0;
            r_exccode  <= 5'h0;
            r_epc      <= 32'h0;
            r_badvaddr <= 32'h0;
        end else begin
            r_ip_hw <= {bus.int_i[5] | r_timer_int, bus.int_i[4:0]};
            if (w_exc) begin
                if (!r_exl) begin
                    r_epc <= bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4 : bus.current_inst_addr_i;
                    r_bd  <= bus.is_in_delayslot_i;
                end
                r_exl     <= 1'b1;
                r_exccode <= bus.excepttype_i == 32'h1 ? 5'h0 : bus.excepttype_i[4:0];
                if (w_badv) r_badvaddr <= bus.bad_addr_i;
            end else if (w_eret) begin
                r_exl <= 1'b0;
            end else if (bus.we_i) begin
                if (bus.waddr_i == 5'd12) {r_im, r_exl, r_ie} <= {bus.data_i[15:8], bus.data_i[1:0]};
                if (bus.waddr_i == 5'd13) r_ip_sw <= bus.data_i[9:8];
                if (bus.waddr_i == 5'd14) r_epc <= bus.data_i;
            end
        end
    end

    // mfc0 read mux over current register state; unimplemented numbers read zero
    always_comb begin
        bus.data_o = bus.raddr_i == 5'd8  ? r_badvaddr :
                     bus.raddr_i == 5'd9  ? r_count :
                     bus.raddr_i == 5'd11 ? r_compare :
                     bus.raddr_i == 5'd12 ? w_status :
                     bus.raddr_i == 5'd13 ? w_cause :
                     bus.raddr_i == 5'd14 ? r_epc : 32'h0;
    end

    assign bus.count_o     = r_count;
    assign bus.compare_o   = r_compare;
    assign bus.status_o    = w_status;
    assign bus.cause_o     = w_cause;
    assign bus.epc_o       = r_epc;
    assign bus.badvaddr_o  = r_badvaddr;
    assign bus.timer_int_o = r_timer_int;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: table-driven check of cp0_regfile plus timer, interrupt-latency and async-reset sequences.
module tb_cp0_regfile;
    logic clk;
    logic resetn;
    int   n_assert;
    int   n_fail;

`ifdef CP0_TIMER_INT_EN
    localparam logic EXP_T = 1'b1;
`else
    localparam logic EXP_T = 1'b0;
`endif

    cp0_if bus ();

    cp0_regfile u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [4:0]  raddr;
        logic [31:0] wdata;
        logic [5:0]  intr;
        logic [31:0] exc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [31:0] e_data;
        logic [31:0] e_status;
        logic [31:0] e_cause;
        logic [31:0] e_epc;
        logic [31:0] e_badv;
    } vec_t;

    vec_t v[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.we_i                = 1'b0;
        bus.waddr_i             = 5'd0;
        bus.data_i              = 32'h0;
        bus.int_i               = 6'h0;
        bus.excepttype_i        = 32'h0;
        bus.current_inst_addr_i = 32'h0;
        bus.is_in_delayslot_i   = 1'b0;
        bus.bad_addr_i          = 32'h0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i    = 1'b1;
        bus.waddr_i = a;
        bus.data_i  = d;
        step();
        idle();
    endtask

    initial begin
        logic ok;
        n_assert = 0;
        n_fail   = 0;
        //          we    wa     ra     wdata          int     exc     pc             ds    bad            data           status         cause          epc            badv
        v[0]  = '{1'b1, 5'd12, 5'd12, 32'hFFFF_FFFF, 6'h00, 32'h0, 32'h0,         1'b0, 32'h0,         32'h0040_FF03, 32'h0040_FF03, 32'h0,         32'h0,         32'h0};
        v[1]  = '{1'b1, 5'd12, 5'd12, 32'h0,         6'h00, 32'h0, 32'h0,         1'b0, 32'h0,         32'h0040_0000, 32'h0040_0000, 32'h0,         32'h0,         32'h0};
        v[2]  = '{1'b1, 5'd13, 5'd13, 32'hFFFF_FFFF, 6'h00, 32'h0, 32'h0,         1'b0, 32'h0,         32'h0000_0300, 32'h0040_0000, 32'h0000_0300, 32'h0,         32'h0};
        v[3]  = '{1'b1, 5'd13, 5'd13, 32'h0,         6'h00, 32'h0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0040_0000, 32'h0,         32'h0,         32'h0};
        v[4]  = '{1'b1, 5'd14, 5'd14, 32'h1234_5678, 6'h00, 32'h0, 32'h0,         1'b0, 32'h0,         32'h1234_5678, 32'h0040_0000, 32'h0,         32'h1234_5678, 32'h0};
        v[5]  = '{1'b1, 5'd8,  5'd8,  32'hDEAD_BEEF, 6'h00, 32'h0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0040_0000, 32'h0,         32'h1234_5678, 32'h0};
        v[6]  = '{1'b1, 5'd10, 5'd10, 32'hFFFF_FFFF, 6'h00, 32'h0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0040_0000, 32'h0,         32'h1234_5678, 32'h0};
        v[7]  = '{1'b0, 5'd0,  5'd14, 32'h0,         6'h00, 32'h4, 32'hBFC0_0100, 1'b1, 32'h3,         32'hBFC0_00FC, 32'h0040_0002, 32'h8000_0010, 32'hBFC0_00FC, 32'h3};
        v[8]  = '{1'b0, 5'd0,  5'd13, 32'h0,         6'h00, 32'h8, 32'h8000_0000, 1'b0, 32'h0,         32'h8000_0020, 32'h0040_0002, 32'h8000_0020, 32'hBFC0_00FC, 32'h3};
        v[9]  = '{1'b0, 5'd0,  5'd12, 32'h0,         6'h00, 32'he, 32'h0,         1'b0, 32'h0,         32'h0040_0000, 32'h0040_0000, 32'h8000_0020, 32'hBFC0_00FC, 32'h3};
        v[10] = '{1'b0, 5'd0,  5'd12, 32'h0,         6'h00, 32'h3, 32'h1111_1110, 1'b1, 32'h7,         32'h0040_0000, 32'h0040_0000, 32'h8000_0020, 32'hBFC0_00FC, 32'h3};
        v[11] = '{1'b1, 5'd12, 5'd12, 32'hFFFF_FFFF, 6'h00, 32'hc, 32'h0000_1000, 1'b0, 32'h0,         32'h0040_0002, 32'h0040_0002, 32'h0000_0030, 32'h0000_1000, 32'h3};
        v[12] = '{1'b1, 5'd14, 5'd14, 32'h5555_5555, 6'h00, 32'he, 32'h0,         1'b0, 32'h0,         32'h0000_1000, 32'h0040_0000, 32'h0000_0030, 32'h0000_1000, 32'h3};
        v[13] = '{1'b0, 5'd0,  5'd13, 32'h0,         6'h01, 32'h1, 32'h0000_2000, 1'b0, 32'h0,         32'h0000_0400, 32'h0040_0002, 32'h0000_0400, 32'h0000_2000, 32'h3};
        v[14] = '{1'b0, 5'd0,  5'd13, 32'h0,         6'h20, 32'h0, 32'h0,         1'b0, 32'h0,         32'h0000_8000, 32'h0040_0002, 32'h0000_8000, 32'h0000_2000, 32'h3};
        v[15] = '{1'b0, 5'd0,  5'd8,  32'h0,         6'h00, 32'h5, 32'h0000_3000, 1'b1, 32'hCAFE_0000, 32'hCAFE_0000, 32'h0040_0002, 32'h0000_0014, 32'h0000_2000, 32'hCAFE_0000};

        idle();
        bus.raddr_i = 5'd12;
        resetn = 1'b0;
        step();
        step();
        chk("reset_rd12", bus.data_o, 32'h0040_0000);
        bus.raddr_i = 5'd13;
        #1;
        chk("reset_rd13", bus.data_o, 32'h0);
        chk("reset_epc", bus.epc_o, 32'h0);
        chk("reset_badv", bus.badvaddr_o, 32'h0);
        chk("reset_timer", {31'b0, bus.timer_int_o}, 32'h0);
        resetn = 1'b1;
        repeat (10) step();
        chk("count_after_10", bus.count_o, 32'd5);
        bus.raddr_i = 5'd9;
        #1;
        chk("rd_count", bus.data_o, 32'd5);

        for (int i = 0; i < 16; i++) begin
            bus.we_i                = v[i].we;
            bus.waddr_i             = v[i].waddr;
            bus.raddr_i             = v[i].raddr;
            bus.data_i              = v[i].wdata;
            bus.int_i               = v[i].intr;
            bus.excepttype_i        = v[i].exc;
            bus.current_inst_addr_i = v[i].pc;
            bus.is_in_delayslot_i   = v[i].ds;
            bus.bad_addr_i          = v[i].bad;
            step();
            idle();
            #1;
            chk($sformatf("v%0d_data", i), bus.data_o, v[i].e_data);
            chk($sformatf("v%0d_status", i), bus.status_o, v[i].e_status);
            chk($sformatf("v%0d_cause", i), bus.cause_o, v[i].e_cause);
            chk($sformatf("v%0d_epc", i), bus.epc_o, v[i].e_epc);
            chk($sformatf("v%0d_badv", i), bus.badvaddr_o, v[i].e_badv);
        end

        bus.int_i = 6'b000001;
        #1;
        chk("int_before_edge", {31'b0, bus.cause_o[10]}, 32'h0);
        step();
        chk("int_after_edge", {31'b0, bus.cause_o[10]}, 32'h1);
        idle();
        step();
        chk("int_drop", {31'b0, bus.cause_o[10]}, 32'h0);

        mtc0(5'd9, 32'h0);
        chk("count_written", bus.count_o, 32'h0);
        mtc0(5'd11, 32'd3);
        chk("compare_written", bus.compare_o, 32'd3);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.count_o == 32'd3) ok = 1'b1;
            else step();
        end
        chk("count_reaches_3", {31'b0, ok}, 32'h1);
        chk("timer_not_yet", {31'b0, bus.timer_int_o}, 32'h0);
        step();
        chk("timer_rise", {31'b0, bus.timer_int_o}, {31'b0, EXP_T});
        chk("ti_rise", {31'b0, bus.cause_o[30]}, {31'b0, EXP_T});
        step();
        chk("ip7_rise", {31'b0, bus.cause_o[15]}, {31'b0, EXP_T});
        repeat (3) step();
        chk("timer_hold", {31'b0, bus.timer_int_o}, {31'b0, EXP_T});
        mtc0(5'd11, 32'h0);
        chk("timer_clear", {31'b0, bus.timer_int_o}, 32'h0);
        chk("ti_clear", {31'b0, bus.cause_o[30]}, 32'h0);
        step();
        chk("ip7_clear", {31'b0, bus.cause_o[15]}, 32'h0);

        bus.excepttype_i        = 32'h4;
        bus.current_inst_addr_i = 32'h4000_0000;
        bus.bad_addr_i          = 32'h1234_0001;
        bus.raddr_i             = 5'd12;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_status", bus.status_o, 32'h0040_0000);
        chk("arst_rd12", bus.data_o, 32'h0040_0000);
        chk("arst_cause", bus.cause_o, 32'h0);
        chk("arst_epc", bus.epc_o, 32'h0);
        chk("arst_badv", bus.badvaddr_o, 32'h0);
        chk("arst_count", bus.count_o, 32'h0);
        chk("arst_compare", bus.compare_o, 32'h0);
        chk("arst_timer", {31'b0, bus.timer_int_o}, 32'h0);
        step();
        chk("arst_commit_lost_epc", bus.epc_o, 32'h0);
        chk("arst_commit_lost_badv", bus.badvaddr_o, 32'h0);
        idle();
        resetn = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
